// File: rtl/csr_unit_pkg.sv
// rtl/csr_unit_pkg.sv - CSR addresses, op encodings, mstatus layout and RMW helper
package csr_unit_pkg;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_t;

    localparam logic [11:0] MSTATUS_ADDR   = 12'h300;
    localparam logic [11:0] MTVEC_ADDR     = 12'h305;
    localparam logic [11:0] MSCRATCH_ADDR  = 12'h340;
    localparam logic [11:0] MEPC_ADDR      = 12'h341;
    localparam logic [11:0] MCAUSE_ADDR    = 12'h342;
    localparam logic [11:0] MCYCLE_ADDR    = 12'hB00;
    localparam logic [11:0] MINSTRET_ADDR  = 12'hB02;
    localparam logic [11:0] MCYCLEH_ADDR   = 12'hB80;
    localparam logic [11:0] MINSTRETH_ADDR = 12'hB82;
    localparam logic [11:0] MVENDORID_ADDR = 12'hF11;
    localparam logic [11:0] MARCHID_ADDR   = 12'hF12;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [63:0] MSTATUS_RESET = 64'h1800;

    // Everything is computed at 64 bits; callers truncate to XLEN.
    function automatic logic [63:0] csr_rmw(csr_op_t op, logic [63:0] old_val,
                                            logic [63:0] operand);
        case (op)
            CSR_OP_RW: return operand;
            CSR_OP_RS: return old_val | operand;
            CSR_OP_RC: return old_val & ~operand;
            default:   return old_val;
        endcase
    endfunction

endpackage

// File: rtl/csr_unit_if.sv
// rtl/csr_unit_if.sv - pipeline-facing CSR access, trap and redirect signals
interface csr_unit_if #(parameter int XLEN = 32);
    import csr_unit_pkg::*;

    csr_op_t           csr_op;
    logic              rs1_is_x0;
    logic [11:0]       csr_addr;
    logic [XLEN-1:0]   csr_wdata;
    logic [XLEN-1:0]   csr_rdata;
    logic              illegal;
    logic              retire;
    logic              trap;
    logic [XLEN-1:0]   trap_cause;
    logic [XLEN-1:0]   trap_pc;
    logic              mret;
    logic [XLEN-1:0]   trap_target;
    logic [XLEN-1:0]   mret_target;
    logic              mie;

    modport master (
        output csr_op, rs1_is_x0, csr_addr, csr_wdata, retire, trap, trap_cause,
               trap_pc, mret,
        input  csr_rdata, illegal, trap_target, mret_target, mie
    );

    modport slave (
        input  csr_op, rs1_is_x0, csr_addr, csr_wdata, retire, trap, trap_cause,
               trap_pc, mret,
        output csr_rdata, illegal, trap_target, mret_target, mie
    );

endinterface

// File: rtl/csr_unit_counter64.sv
// rtl/csr_unit_counter64.sv - 64-bit free-running counter with per-half write override
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [63:0] wdata,
    output logic [63:0] value
);

    // A write to either half wins over the increment for that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) value[31:0]  <= wdata[31:0];
            if (wr_hi) value[63:32] <= wdata[63:32];
        end else if (inc) begin
            value <= value + 64'd1;
        end
    end

endmodule

// File: rtl/csr_unit.sv
// rtl/csr_unit.sv - machine-mode CSR file with trap/MRET handling and counters
module csr_unit
    import csr_unit_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = XLEN'(32'h8000_0000),
    parameter logic [XLEN-1:0] MVENDORID   = '0,
    parameter logic [XLEN-1:0] MARCHID     = '0
) (
    input  logic      clk,
    input  logic      rst,
    csr_unit_if.slave bus
);

    logic            mstatus_mie;
    logic            mstatus_mpie;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mscratch;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic [63:0]     mcycle;
    logic [63:0]     minstret;

    logic [63:0]     old64;
    logic [63:0]     new64;
    logic [XLEN-1:0] wnew;
    logic            implemented;
    logic            write_req;
    logic            illegal;
    logic            we;

    always_comb begin
        old64       = '0;
        implemented = 1'b1;
        case (bus.csr_addr)
            MSTATUS_ADDR: begin
                old64               = MSTATUS_RESET;
                old64[MSTATUS_MIE]  = mstatus_mie;
                old64[MSTATUS_MPIE] = mstatus_mpie;
            end
            MTVEC_ADDR:     old64 = 64'(mtvec);
            MSCRATCH_ADDR:  old64 = 64'(mscratch);
            MEPC_ADDR:      old64 = 64'(mepc);
            MCAUSE_ADDR:    old64 = 64'(mcause);
            MCYCLE_ADDR:    old64 = (XLEN == 32) ? {32'b0, mcycle[31:0]} : mcycle;
            MINSTRET_ADDR:  old64 = (XLEN == 32) ? {32'b0, minstret[31:0]} : minstret;
            MCYCLEH_ADDR: begin
                implemented = (XLEN == 32);
                old64       = {32'b0, mcycle[63:32]};
            end
            MINSTRETH_ADDR: begin
                implemented = (XLEN == 32);
                old64       = {32'b0, minstret[63:32]};
            end
            MVENDORID_ADDR: old64 = 64'(MVENDORID);
            MARCHID_ADDR:   old64 = 64'(MARCHID);
            default:        implemented = 1'b0;
        endcase
        if (!implemented) old64 = '0;
    end

    always_comb begin
        write_req = (bus.csr_op == CSR_OP_RW) ||
                    ((bus.csr_op != CSR_OP_NONE) && !bus.rs1_is_x0);
        // Address space 0xC00-0xFFF is read-only by encoding.
        illegal   = (bus.csr_op != CSR_OP_NONE) &&
                    (!implemented || ((bus.csr_addr[11:10] == 2'b11) && write_req));
        we        = write_req && !illegal && !bus.trap;
        new64     = csr_rmw(bus.csr_op, old64, 64'(bus.csr_wdata));
        wnew      = new64[XLEN-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mtvec        <= MTVEC_RESET;
            mscratch     <= '0;
            mepc         <= '0;
            mcause       <= '0;
        end else if (bus.trap) begin
            mepc         <= {bus.trap_pc[XLEN-1:2], 2'b00};
            mcause       <= bus.trap_cause;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else begin
            if (bus.mret) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end
            if (we) begin
                case (bus.csr_addr)
                    MSTATUS_ADDR: begin
                        if (!bus.mret) begin
                            mstatus_mie  <= wnew[MSTATUS_MIE];
                            mstatus_mpie <= wnew[MSTATUS_MPIE];
                        end
                    end
                    MTVEC_ADDR:    mtvec    <= {wnew[XLEN-1:2], 2'b00};
                    MSCRATCH_ADDR: mscratch <= wnew;
                    MEPC_ADDR:     mepc     <= {wnew[XLEN-1:2], 2'b00};
                    MCAUSE_ADDR:   mcause   <= wnew;
                    default: ;
                endcase
            end
        end
    end

    logic [63:0] cnt_wdata;
    logic        cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi;

    // With XLEN=64 the low address covers the whole counter.
    always_comb begin
        cnt_wdata = (XLEN == 32) ? {new64[31:0], new64[31:0]} : new64;
        cyc_wr_lo = we && (bus.csr_addr == MCYCLE_ADDR);
        ins_wr_lo = we && (bus.csr_addr == MINSTRET_ADDR);
        cyc_wr_hi = (XLEN == 32) ? (we && (bus.csr_addr == MCYCLEH_ADDR))   : cyc_wr_lo;
        ins_wr_hi = (XLEN == 32) ? (we && (bus.csr_addr == MINSTRETH_ADDR)) : ins_wr_lo;
    end

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .wr_lo (cyc_wr_lo),
        .wr_hi (cyc_wr_hi),
        .wdata (cnt_wdata),
        .value (mcycle)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (bus.retire),
        .wr_lo (ins_wr_lo),
        .wr_hi (ins_wr_hi),
        .wdata (cnt_wdata),
        .value (minstret)
    );

    assign bus.csr_rdata   = old64[XLEN-1:0];
    assign bus.illegal     = illegal;
    assign bus.trap_target = {mtvec[XLEN-1:2], 2'b00};
    assign bus.mret_target = mepc;
    assign bus.mie         = mstatus_mie;

endmodule

// File: tb/tb_csr_unit.sv
// tb/tb_csr_unit.sv - randomized self-checking bench for csr_unit against a reference model
module tb_csr_unit;
    import csr_unit_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    csr_unit_if #(.XLEN(XLEN)) bus ();

    csr_unit #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic        m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] m_cycle, m_instret;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] last_rdata;
    logic        last_illegal;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic bit model_read(input logic [11:0] a, output logic [31:0] v);
        v = 32'h0;
        case (a)
            12'h300: v = 32'h1800 + (m_mie ? 32'd8 : 32'd0) + (m_mpie ? 32'd128 : 32'd0);
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'hB00: v = m_cycle[31:0];
            12'hB80: v = m_cycle[63:32];
            12'hB02: v = m_instret[31:0];
            12'hB82: v = m_instret[63:32];
            12'hF11: v = 32'h0;
            12'hF12: v = 32'h0;
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_mie = 0; m_mpie = 0; m_mtvec = 32'h8000_0000;
        m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_cycle = 0; m_instret = 0;
    endtask

    task automatic set_idle();
        bus.csr_op = CSR_OP_NONE; bus.rs1_is_x0 = 0; bus.csr_addr = 0; bus.csr_wdata = 0;
        bus.retire = 0; bus.trap = 0; bus.trap_cause = 0; bus.trap_pc = 0; bus.mret = 0;
    endtask

    task automatic do_cycle(input logic [1:0] op, input bit x0, input logic [11:0] a,
                            input logic [31:0] wd, input bit ret, input bit tr,
                            input logic [31:0] cause, input logic [31:0] pc, input bit mr);
        logic [31:0] old, nv;
        bit impl, is_write, exp_ill, do_wr, cyc_w, ins_w;
        bus.csr_op = csr_op_t'(op); bus.rs1_is_x0 = x0; bus.csr_addr = a; bus.csr_wdata = wd;
        bus.retire = ret; bus.trap = tr; bus.trap_cause = cause; bus.trap_pc = pc; bus.mret = mr;
        @(negedge clk);
        impl     = model_read(a, old);
        is_write = (op == 2'd1) || (op != 2'd0 && !x0);
        exp_ill  = (op != 2'd0) && (!impl || (a[11:10] == 2'b11 && is_write));
        check("illegal", bus.illegal, exp_ill);
        if (impl) check("rdata", bus.csr_rdata, old);
        check("mie", bus.mie, m_mie);
        check("trap_target", bus.trap_target, m_mtvec & ~32'd3);
        check("mret_target", bus.mret_target, m_mepc);
        last_rdata   = bus.csr_rdata;
        last_illegal = bus.illegal;

        nv    = (op == 2'd1) ? wd : (op == 2'd2) ? (old | wd) : (old & ~wd);
        do_wr = is_write && !exp_ill && !tr;
        cyc_w = 0; ins_w = 0;
        if (tr) begin
            m_mepc = pc & ~32'd3; m_mcause = cause; m_mpie = m_mie; m_mie = 0;
        end else begin
            if (mr) begin m_mie = m_mpie; m_mpie = 1; end
            if (do_wr) begin
                case (a)
                    12'h300: if (!mr) begin m_mie = nv[3]; m_mpie = nv[7]; end
                    12'h305: m_mtvec = nv & ~32'd3;
                    12'h340: m_mscratch = nv;
                    12'h341: m_mepc = nv & ~32'd3;
                    12'h342: m_mcause = nv;
                    12'hB00: begin m_cycle[31:0] = nv;    cyc_w = 1; end
                    12'hB80: begin m_cycle[63:32] = nv;   cyc_w = 1; end
                    12'hB02: begin m_instret[31:0] = nv;  ins_w = 1; end
                    12'hB82: begin m_instret[63:32] = nv; ins_w = 1; end
                    default: ;
                endcase
            end
        end
        if (!cyc_w) m_cycle = m_cycle + 64'd1;
        if (!ins_w && ret) m_instret = m_instret + 64'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] a);
        do_cycle(2'd2, 1'b1, a, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    logic [11:0] addr_tab [13] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00,
                                   12'hB02, 12'hB80, 12'hB82, 12'hF11, 12'hF12, 12'h7C0,
                                   12'h301};

    initial begin
        set_idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        model_reset();

        rd(12'h300); check("rst_mstatus", last_rdata, 32'h1800);
        rd(12'h305); check("rst_mtvec", last_rdata, 32'h8000_0000);
        rd(12'hB00); check("rst_mcycle", last_rdata, 32'd2);

        do_cycle(2'd1, 0, 12'h340, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        check("rw_old", last_rdata, 32'h0);
        do_cycle(2'd2, 0, 12'h340, 32'h1, 0, 0, 0, 0, 0);
        check("rs_old", last_rdata, 32'hDEAD_BEEF);
        rd(12'h340); check("mscratch", last_rdata, 32'hDEAD_BEEF);

        rd(12'hF11); check("vendor_ill", last_illegal, 1'b0); check("vendor", last_rdata, 32'h0);
        do_cycle(2'd1, 0, 12'hF11, 32'h1234, 0, 0, 0, 0, 0);
        check("ro_write_ill", last_illegal, 1'b1);
        rd(12'h7C0); check("unimpl_ill", last_illegal, 1'b1);

        do_cycle(2'd1, 0, 12'h300, 32'h8, 0, 0, 0, 0, 0);
        rd(12'h300); check("mstatus_set", last_rdata, 32'h1808);
        do_cycle(2'd0, 0, 12'h0, 0, 0, 1, 32'd11, 32'h8000_0102, 0);
        rd(12'h341); check("trap_mepc", last_rdata, 32'h8000_0100);
        rd(12'h342); check("trap_mcause", last_rdata, 32'd11);
        rd(12'h300); check("trap_mstatus", last_rdata, 32'h1880);
        check("mret_target_c", bus.mret_target, 32'h8000_0100);
        check("trap_target_c", bus.trap_target, 32'h8000_0000);
        do_cycle(2'd0, 0, 12'h0, 0, 0, 0, 0, 0, 1);
        rd(12'h300); check("mret_mstatus", last_rdata, 32'h1888);

        do_cycle(2'd1, 0, 12'h341, 32'h5555, 0, 1, 32'd7, 32'h0000_1234, 0);
        rd(12'h341); check("trap_vs_write", last_rdata, 32'h1234);

        do_cycle(2'd1, 0, 12'hB00, 32'hFFFF_FFFF, 1, 0, 0, 0, 0);
        rd(12'hB00); check("mcycle_wr", last_rdata, 32'hFFFF_FFFF);
        rd(12'hB80); check("mcycle_carry", last_rdata, 32'd1);
        do_cycle(2'd1, 0, 12'hB02, 32'd5, 1, 0, 0, 0, 0);
        rd(12'hB02); check("minstret_wr", last_rdata, 32'd5);
        do_cycle(2'd2, 1, 12'hB02, 0, 1, 0, 0, 0, 0);
        check("minstret_hold", last_rdata, 32'd5);
        rd(12'hB02); check("minstret_ret", last_rdata, 32'd6);

        for (int i = 0; i < 600; i++) begin
            logic [31:0] wd;
            wd = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            do_cycle(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                     addr_tab[$urandom_range(0, 12)], wd, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 11) == 0), $urandom, $urandom,
                     ($urandom_range(0, 9) == 0));
        end

        bus.csr_op = CSR_OP_RW; bus.csr_addr = 12'h340; bus.csr_wdata = 32'hA5A5_A5A5;
        bus.trap = 1; bus.trap_pc = 32'h44; bus.mret = 1; bus.retire = 1;
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        set_idle();
        model_reset();
        rd(12'h340); check("rst_override", last_rdata, 32'h0);
        rd(12'h341); check("rst_mepc", last_rdata, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
